// File: rtl/control_unit_pkg.sv
// Shared definitions for the accumulator-machine control unit:
// state and opcode encodings, A-mux selects and the control-word layout.
package control_unit_pkg;

  typedef enum logic [3:0] {
    S_START,
    S_FETCH,
    S_DECODE,
    S_LOAD,
    S_STORE,
    S_ADD,
    S_SUB,
    S_INPUT,
    S_JZ,
    S_JPOS,
    S_HALT
  } state_t;

  typedef enum logic [2:0] {
    OP_LOAD  = 3'b000,
    OP_STORE = 3'b001,
    OP_ADD   = 3'b010,
    OP_SUB   = 3'b011,
    OP_IN    = 3'b100,
    OP_JZ    = 3'b101,
    OP_JPOS  = 3'b110,
    OP_HALT  = 3'b111
  } opcode_t;

  localparam logic [1:0] ASEL_SUB  = 2'd0;
  localparam logic [1:0] ASEL_IN   = 2'd1;
  localparam logic [1:0] ASEL_OPND = 2'd2;
  localparam logic [1:0] ASEL_GND  = 2'd3;

  typedef struct packed {
    logic       IRload;
    logic       PCload;
    logic       JMPmux;
    logic       Meminst;
    logic       MemWr;
    logic [1:0] Asel;
    logic       loadA;
    logic       clearA;
    logic       sub;
    logic       Halt;
  } ctrl_t;

  // Quiescent word: clearA is active-low and Asel parks on GND.
  localparam ctrl_t CTRL_IDLE = '{
    IRload:  1'b0,
    PCload:  1'b0,
    JMPmux:  1'b0,
    Meminst: 1'b0,
    MemWr:   1'b0,
    Asel:    ASEL_GND,
    loadA:   1'b0,
    clearA:  1'b1,
    sub:     1'b0,
    Halt:    1'b0
  };

  function automatic state_t exec_state(input opcode_t op);
    state_t s;
    s = S_HALT;
    case (op)
      OP_LOAD:  s = S_LOAD;
      OP_STORE: s = S_STORE;
      OP_ADD:   s = S_ADD;
      OP_SUB:   s = S_SUB;
      OP_IN:    s = S_INPUT;
      OP_JZ:    s = S_JZ;
      OP_JPOS:  s = S_JPOS;
      OP_HALT:  s = S_HALT;
      default:  s = S_HALT;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/control_unit_if.sv
// Bundle between the control unit and the datapath/PC/memory it steers.
interface control_unit_if #(
  parameter int OPW = 3
);
  logic [OPW-1:0] opcode;
  logic           Aeq0;
  logic           Apos;
  logic           Enter;
  logic           IRload;
  logic           PCload;
  logic           JMPmux;
  logic           Meminst;
  logic           MemWr;
  logic [1:0]     Asel;
  logic           loadA;
  logic           clearA;
  logic           sub;
  logic           Halt;

  modport master (
    input  opcode, Aeq0, Apos, Enter,
    output IRload, PCload, JMPmux, Meminst, MemWr, Asel, loadA, clearA, sub, Halt
  );

  modport slave (
    output opcode, Aeq0, Apos, Enter,
    input  IRload, PCload, JMPmux, Meminst, MemWr, Asel, loadA, clearA, sub, Halt
  );
endinterface

// File: rtl/control_unit_output_decode.sv
// Combinational control-word decode: Moore per state, except the INPUT load
// strobe (Enter) and the conditional-branch PC load (flags).
import control_unit_pkg::*;

module cu_output_decode (
  input  state_t state_i,
  input  logic   Aeq0_i,
  input  logic   Apos_i,
  input  logic   Enter_i,
  output ctrl_t  ctrl_o
);

  always_comb begin
    ctrl_o = CTRL_IDLE;
    case (state_i)
      S_START: ctrl_o.clearA = 1'b0;
      S_FETCH: begin
        ctrl_o.Meminst = 1'b1;
        ctrl_o.IRload  = 1'b1;
        ctrl_o.PCload  = 1'b1;
        ctrl_o.JMPmux  = 1'b0;
      end
      S_DECODE: ctrl_o.Meminst = 1'b0;
      S_LOAD: begin
        ctrl_o.Asel  = ASEL_OPND;
        ctrl_o.loadA = 1'b1;
      end
      S_STORE: begin
        ctrl_o.Meminst = 1'b0;
        ctrl_o.MemWr   = 1'b1;
      end
      S_ADD: begin
        ctrl_o.Asel  = ASEL_SUB;
        ctrl_o.loadA = 1'b1;
      end
      S_SUB: begin
        ctrl_o.Asel  = ASEL_SUB;
        ctrl_o.sub   = 1'b1;
        ctrl_o.loadA = 1'b1;
      end
      S_INPUT: begin
        ctrl_o.Asel  = ASEL_IN;
        ctrl_o.loadA = Enter_i;
      end
      S_JZ: begin
        ctrl_o.PCload = Aeq0_i;
        ctrl_o.JMPmux = Aeq0_i;
      end
      S_JPOS: begin
        ctrl_o.PCload = Apos_i;
        ctrl_o.JMPmux = Apos_i;
      end
      S_HALT: ctrl_o.Halt = 1'b1;
      default: ctrl_o = CTRL_IDLE;
    endcase
  end

endmodule

// File: rtl/control_unit.sv
// Fetch/decode/execute sequencer: state register and next-state logic here,
// control word decoded by cu_output_decode from the current state.
import control_unit_pkg::*;

module control_unit #(
  parameter int OPW = 3
) (
  input logic            clk,
  input logic            clear,
  control_unit_if.master cu
);

  state_t         state_q, state_d;
  ctrl_t          ctrl;
  logic [OPW-1:0] op;

  assign op = cu.opcode;

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_START:  state_d = S_FETCH;
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: state_d = exec_state(opcode_t'(op[2:0]));
      S_LOAD, S_STORE, S_ADD, S_SUB, S_JZ, S_JPOS: state_d = S_FETCH;
      S_INPUT:  state_d = cu.Enter ? S_FETCH : S_INPUT;
      S_HALT:   state_d = S_HALT;
      default:  state_d = S_START;
    endcase
  end

  always_ff @(posedge clk or negedge clear) begin
    if (!clear) state_q <= S_START;
    else        state_q <= state_d;
  end

  cu_output_decode u_decode (
    .state_i (state_q),
    .Aeq0_i  (cu.Aeq0),
    .Apos_i  (cu.Apos),
    .Enter_i (cu.Enter),
    .ctrl_o  (ctrl)
  );

  // Outputs follow the state register directly so an asynchronous clear
  // drops MemWr/loadA in the same cycle.
  assign cu.IRload  = ctrl.IRload;
  assign cu.PCload  = ctrl.PCload;
  assign cu.JMPmux  = ctrl.JMPmux;
  assign cu.Meminst = ctrl.Meminst;
  assign cu.MemWr   = ctrl.MemWr;
  assign cu.Asel    = ctrl.Asel;
  assign cu.loadA   = ctrl.loadA;
  assign cu.clearA  = ctrl.clearA;
  assign cu.sub     = ctrl.sub;
  assign cu.Halt    = ctrl.Halt;

endmodule

// File: tb/tb_control_unit.sv
// Directed bench for control_unit; output word packed as
// {IRload,PCload,JMPmux,Meminst,MemWr,Asel[1:0],loadA,clearA,sub,Halt}.
module tb_control_unit;

  logic clk;
  logic clear;
  int   checks;
  int   errors;

  control_unit_if #(.OPW(3)) bus ();

  control_unit #(.OPW(3)) dut (
    .clk   (clk),
    .clear (clear),
    .cu    (bus)
  );

  localparam logic [10:0] V_START = 11'b00000_11_0000;
  localparam logic [10:0] V_FETCH = 11'b11010_11_0100;
  localparam logic [10:0] V_IDLE  = 11'b00000_11_0100;
  localparam logic [10:0] V_LOAD  = 11'b00000_10_1100;
  localparam logic [10:0] V_STORE = 11'b00001_11_0100;
  localparam logic [10:0] V_ADD   = 11'b00000_00_1100;
  localparam logic [10:0] V_SUB   = 11'b00000_00_1110;
  localparam logic [10:0] V_INW   = 11'b00000_01_0100;
  localparam logic [10:0] V_INL   = 11'b00000_01_1100;
  localparam logic [10:0] V_JMP   = 11'b01100_11_0100;
  localparam logic [10:0] V_HALT  = 11'b00000_11_0101;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [10:0] outs();
    return {bus.IRload, bus.PCload, bus.JMPmux, bus.Meminst, bus.MemWr,
            bus.Asel, bus.loadA, bus.clearA, bus.sub, bus.Halt};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    clear = 1'b0; bus.opcode = 3'b000; bus.Aeq0 = 1'b0; bus.Apos = 1'b0; bus.Enter = 1'b0;
    #2;
    checks++; if (outs() !== V_START) begin errors++; $display("FAIL reset_async: got %b want %b", outs(), V_START); end
    tick();
    checks++; if (outs() !== V_START) begin errors++; $display("FAIL reset_hold: got %b want %b", outs(), V_START); end
    clear = 1'b1;
    tick();
    checks++; if (outs() !== V_FETCH) begin errors++; $display("FAIL reset_fetch: got %b want %b", outs(), V_FETCH); end
  endtask

  task automatic test_add_sub();
    bus.opcode = 3'b010;
    tick();
    checks++; if (outs() !== V_IDLE) begin errors++; $display("FAIL add_decode: got %b want %b", outs(), V_IDLE); end
    tick();
    checks++; if (outs() !== V_ADD) begin errors++; $display("FAIL add_exec: got %b want %b", outs(), V_ADD); end
    tick();
    checks++; if (outs() !== V_FETCH) begin errors++; $display("FAIL add_refetch: got %b want %b", outs(), V_FETCH); end
    bus.opcode = 3'b011;
    tick(); tick();
    checks++; if (outs() !== V_SUB) begin errors++; $display("FAIL sub_exec: got %b want %b", outs(), V_SUB); end
    tick();
    checks++; if (outs() !== V_FETCH) begin errors++; $display("FAIL sub_refetch: got %b want %b", outs(), V_FETCH); end
  endtask

  task automatic test_load_store();
    bus.opcode = 3'b000;
    tick(); tick();
    checks++; if (outs() !== V_LOAD) begin errors++; $display("FAIL load_exec: got %b want %b", outs(), V_LOAD); end
    tick();
    bus.opcode = 3'b001;
    tick(); tick();
    checks++; if (outs() !== V_STORE) begin errors++; $display("FAIL store_exec: got %b want %b", outs(), V_STORE); end
    tick();
    checks++; if (outs() !== V_FETCH) begin errors++; $display("FAIL store_refetch: got %b want %b", outs(), V_FETCH); end
  endtask

  task automatic test_input();
    bus.opcode = 3'b100; bus.Enter = 1'b0;
    tick(); tick();
    for (int i = 0; i < 3; i++) begin
      checks++; if (outs() !== V_INW) begin errors++; $display("FAIL input_wait%0d: got %b want %b", i, outs(), V_INW); end
      tick();
    end
    checks++; if (outs() !== V_INW) begin errors++; $display("FAIL input_wait3: got %b want %b", outs(), V_INW); end
    bus.Enter = 1'b1;
    #1;
    checks++; if (outs() !== V_INL) begin errors++; $display("FAIL input_load: got %b want %b", outs(), V_INL); end
    tick();
    checks++; if (outs() !== V_FETCH) begin errors++; $display("FAIL input_refetch: got %b want %b", outs(), V_FETCH); end
  endtask

  task automatic test_back_to_back();
    bus.opcode = 3'b100; bus.Enter = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++; if (outs() !== V_IDLE) begin errors++; $display("FAIL b2b_decode%0d: got %b want %b", i, outs(), V_IDLE); end
      tick();
      checks++; if (outs() !== V_INL) begin errors++; $display("FAIL b2b_input%0d: got %b want %b", i, outs(), V_INL); end
      tick();
      checks++; if (outs() !== V_FETCH) begin errors++; $display("FAIL b2b_fetch%0d: got %b want %b", i, outs(), V_FETCH); end
    end
    bus.Enter = 1'b0;
  endtask

  task automatic test_branch();
    bus.opcode = 3'b101; bus.Aeq0 = 1'b1; bus.Apos = 1'b0;
    tick(); tick();
    checks++; if (outs() !== V_JMP) begin errors++; $display("FAIL jz_taken: got %b want %b", outs(), V_JMP); end
    bus.Aeq0 = 1'b0; bus.Apos = 1'b1;
    #1;
    checks++; if (outs() !== V_IDLE) begin errors++; $display("FAIL jz_flag_drop: got %b want %b", outs(), V_IDLE); end
    tick();
    bus.Aeq0 = 1'b0; bus.Apos = 1'b1;
    tick(); tick();
    checks++; if (outs() !== V_IDLE) begin errors++; $display("FAIL jz_not_taken: got %b want %b", outs(), V_IDLE); end
    tick();
    bus.opcode = 3'b110; bus.Apos = 1'b1; bus.Aeq0 = 1'b0;
    tick(); tick();
    checks++; if (outs() !== V_JMP) begin errors++; $display("FAIL jpos_taken: got %b want %b", outs(), V_JMP); end
    tick();
    bus.Apos = 1'b0; bus.Aeq0 = 1'b0;
    tick(); tick();
    checks++; if (outs() !== V_IDLE) begin errors++; $display("FAIL jpos_negative: got %b want %b", outs(), V_IDLE); end
    tick();
    checks++; if (outs() !== V_FETCH) begin errors++; $display("FAIL jpos_refetch: got %b want %b", outs(), V_FETCH); end
  endtask

  task automatic test_clear_mid_store();
    bus.opcode = 3'b001;
    tick(); tick();
    checks++; if (outs() !== V_STORE) begin errors++; $display("FAIL midstore_exec: got %b want %b", outs(), V_STORE); end
    clear = 1'b0;
    #1;
    checks++; if (outs() !== V_START) begin errors++; $display("FAIL midstore_clear: got %b want %b", outs(), V_START); end
    #1 clear = 1'b1;
    tick();
    checks++; if (outs() !== V_FETCH) begin errors++; $display("FAIL midstore_restart: got %b want %b", outs(), V_FETCH); end
  endtask

  task automatic test_halt();
    bus.opcode = 3'b111;
    tick(); tick();
    for (int i = 0; i < 12; i++) begin
      checks++; if (outs() !== V_HALT) begin errors++; $display("FAIL halt_hold%0d: got %b want %b", i, outs(), V_HALT); end
      bus.opcode = 3'(i); bus.Enter = i[0]; bus.Aeq0 = i[1]; bus.Apos = ~i[1];
      tick();
    end
    bus.Enter = 1'b0;
    clear = 1'b0;
    #1;
    checks++; if (outs() !== V_START) begin errors++; $display("FAIL halt_clear: got %b want %b", outs(), V_START); end
    #1 clear = 1'b1;
    tick();
    checks++; if (outs() !== V_FETCH) begin errors++; $display("FAIL halt_restart: got %b want %b", outs(), V_FETCH); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_add_sub();
    test_load_store();
    test_input();
    test_back_to_back();
    test_branch();
    test_clear_mid_store();
    test_halt();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
